// File: rtl/requester_pkg.sv
// requester_pkg: shared sample width, FSM state type and default timing for codec_sample_requester.
`default_nettype none

package requester_pkg;

  localparam int SAMPLE_W            = 16;
  localparam int DEF_CLKS_PER_SAMPLE = 1024;
  localparam int DEF_TIMEOUT_CYCLES  = 512;
  localparam int DEF_BIT_DIV         = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sample_serializer.sv
// sample_serializer: shifts a loaded sample out MSB first, BIT_DIV clocks per bit, frame_sync on bit 15.
`default_nettype none

module sample_serializer
  import requester_pkg::*;
#(
  parameter int BIT_DIV = DEF_BIT_DIV
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SAMPLE_W-1:0] data,
  output logic                sdata,
  output logic                frame_sync,
  output logic                busy
);

  localparam int                   DIV_W     = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(BIT_DIV - 1);
  localparam int                   IDX_W     = $clog2(SAMPLE_W);
  localparam logic [IDX_W-1:0]     IDX_FIRST = IDX_W'(SAMPLE_W - 1);

  logic [SAMPLE_W-1:0] shreg;
  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    bit_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      div_cnt    <= '0;
      bit_idx    <= '0;
      sdata      <= 1'b0;
      frame_sync <= 1'b0;
      busy       <= 1'b0;
    end else if (load) begin
      shreg      <= data;
      sdata      <= data[SAMPLE_W-1];
      frame_sync <= 1'b1;
      busy       <= 1'b1;
      div_cnt    <= '0;
      bit_idx    <= IDX_FIRST;
    end else if (busy) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt    <= '0;
        frame_sync <= 1'b0;
        if (bit_idx == '0) begin
          busy  <= 1'b0;
          sdata <= 1'b0;
        end else begin
          // shreg[SAMPLE_W-1] is always the bit currently on sdata
          shreg   <= {shreg[SAMPLE_W-2:0], 1'b0};
          sdata   <= shreg[SAMPLE_W-2];
          bit_idx <= bit_idx - 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/codec_sample_requester.sv
// codec_sample_requester: paces sample requests, captures final_sample, serializes it to the DAC, counts underruns.
// Option: define REQUESTER_UNDERRUN_MUTE_EN to send silence instead of repeating the last sample on timeout.
`default_nettype none

module codec_sample_requester
  import requester_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = DEF_CLKS_PER_SAMPLE,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int BIT_DIV         = DEF_BIT_DIV
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                generate_next_sample,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0] held_sample,
  output logic                sdata,
  output logic                frame_sync,
  output logic                busy,
  output logic [7:0]          underrun_count
);

  localparam int                PER_W      = $clog2(CLKS_PER_SAMPLE);
  localparam logic [PER_W-1:0]  PER_LAST   = PER_W'(CLKS_PER_SAMPLE - 1);
  localparam int                WAIT_W     = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

`ifdef REQUESTER_UNDERRUN_MUTE_EN
  localparam logic MUTE_ON_UNDERRUN = 1'b1;
`else
  localparam logic MUTE_ON_UNDERRUN = 1'b0;
`endif

  state_t              state;
  logic [PER_W-1:0]    period_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_next;
  logic                tick;
  logic                in_window;
  logic                capture;
  logic                timeout;
  logic                load;
  logic [SAMPLE_W-1:0] load_data;

  assign tick      = enable && (period_cnt == PER_LAST);
  assign wait_next = wait_cnt + 1'b1;
  // ready coinciding with the request pulse belongs to no request yet
  assign in_window = (state == WAIT) && enable && !generate_next_sample;
  assign capture   = in_window && new_sample_ready;
  assign timeout   = in_window && (wait_next >= WAIT_LIMIT);
  assign load      = capture || timeout;
  assign load_data = capture          ? sample_in :
                     MUTE_ON_UNDERRUN ? '0        : held_sample;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      period_cnt           <= '0;
      wait_cnt             <= '0;
      generate_next_sample <= 1'b0;
      held_sample          <= '0;
      underrun_count       <= '0;
    end else begin
      generate_next_sample <= 1'b0;
      period_cnt <= (!enable || period_cnt == PER_LAST) ? '0 : period_cnt + 1'b1;

      if (load) held_sample <= load_data;
      if (timeout && !capture && underrun_count != 8'hFF)
        underrun_count <= underrun_count + 1'b1;

      case (state)
        IDLE: begin
          if (tick) begin
            generate_next_sample <= 1'b1;
            wait_cnt             <= '0;
            state                <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_next;
          if (!enable || load) state <= IDLE;
        end
      endcase
    end
  end

  sample_serializer #(
    .BIT_DIV (BIT_DIV)
  ) u_serializer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data       (load_data),
    .sdata      (sdata),
    .frame_sync (frame_sync),
    .busy       (busy)
  );

endmodule

`default_nettype wire

// File: doc/codec_sample_requester.md
# codec_sample_requester

Paces the sample pipeline from the codec end. Issues a one-cycle `generate_next_sample` request once per audio sample period and waits for the chain's `new_sample_ready`. Captures the 16-bit `final_sample` into a holding register and shifts it out MSB-first as a framed serial word to the DAC. Sits between the last stage of the note/dynamics chain and the codec pins, and counts missed deadlines (underruns).

## Interface
- `CLKS_PER_SAMPLE`, default 1024: clock cycles per sample period.
- `TIMEOUT_CYCLES`, default 512: maximum wait for `new_sample_ready` after a request.
- `BIT_DIV`, default 8: clock cycles per serial bit.
- Parameter constraints: `TIMEOUT_CYCLES <= CLKS_PER_SAMPLE-2` and `16*BIT_DIV+2 <= CLKS_PER_SAMPLE`.

Ports:
- `clk`, in, 1: single system clock, rising edge.
- `reset`, in, 1: asynchronous, active-low (asserted at 0).
- `enable`, in, 1: playback enable.
- `generate_next_sample`, out, 1: one-cycle request pulse to the sample chain.
- `new_sample_ready`, in, 1: chain reports that `sample_in` is valid this cycle.
- `sample_in`, in, 16: `final_sample` from the dynamics stage.
- `held_sample`, out, 16: last captured (or substituted) sample.
- `sdata`, out, 1: serial data, MSB first.
- `frame_sync`, out, 1: high during bit 15 of each word.
- `busy`, out, 1: serializer shifting.
- `underrun_count`, out, 8: saturating timeout counter.

## Operation
- Period counter runs 0..`CLKS_PER_SAMPLE`-1 while `enable`=1 and wraps. The wrap cycle is the tick.
- State machine states: IDLE, WAIT.
  - IDLE, on tick: register `generate_next_sample`=1 for exactly one cycle, clear the wait counter, go to WAIT.
  - WAIT, `new_sample_ready`=1: `held_sample`<=`sample_in`, start the serializer, go to IDLE.
  - WAIT, wait counter reaches `TIMEOUT_CYCLES`: underrun. `underrun_count`+=1, saturating at 255. Re-send `held_sample` unchanged. Go to IDLE.
- `new_sample_ready` in IDLE is ignored. Ready in the same cycle as the request pulse is also ignored.
- Ready and timeout on the same edge: ready wins; no underrun is counted.
- `enable` low:
  - The period counter is forced to 0.
  - WAIT aborts to IDLE with no underrun.
  - No new requests are issued.
  - The serializer finishes the word in flight.
- Serializer:
  - Loads the 16-bit word and holds each bit for `BIT_DIV` cycles, MSB first.
  - `frame_sync`=1 only while bit 15 is on `sdata`.
  - After bit 0, `sdata`=0 and `busy`=0.

## Timing
- Reset values: `generate_next_sample` 0, `held_sample` 0, `sdata` 0, `frame_sync` 0, `busy` 0, `underrun_count` 0, state IDLE, all counters 0.
- Reset mid-operation clears everything immediately, including a word in flight.
- First request pulse is high after the `CLKS_PER_SAMPLE`-th rising edge at which `enable` is sampled 1.
- Later requests follow every `CLKS_PER_SAMPLE` cycles.
- Capture: ready sampled 1 at edge E means `held_sample` is valid after E. From E+1, `sdata`=bit15 and `frame_sync`=1 for `BIT_DIV` cycles.
- A full word occupies 16·`BIT_DIV` cycles.
- A timeout at edge E starts the re-send at E+1, with the same framing.

## Configuration
- Macro `REQUESTER_UNDERRUN_MUTE_EN`.
- Defined: on timeout, `held_sample`<=0 and the serializer sends 0 (mute).
- Undefined: on timeout, the previous `held_sample` is repeated.
- `underrun_count` behaves identically in both builds.

## Structure
- Shared package `requester_pkg` holds:
  - `SAMPLE_W`=16.
  - State enum (IDLE, WAIT).
  - Default values for `CLKS_PER_SAMPLE`, `TIMEOUT_CYCLES`, `BIT_DIV`.
- One sub-module, `sample_serializer`, containing the load, bit-divider, shift register and `frame_sync` logic.
- Top level holds the period counter, wait counter, FSM, holding register and underrun counter.

## Test plan
All scenarios use `CLKS_PER_SAMPLE`=64, `TIMEOUT_CYCLES`=16, `BIT_DIV`=2.
1. Reset asserted, then released with `enable`=1 -> all outputs 0. Single request pulse after the 64th enabled edge, then every 64 cycles.
2. Ready 3 cycles after the request with `sample_in`=10400 (0x28A0) -> `held_sample`=10400. `sdata` sends 0010100010100000, 2 cycles per bit. `frame_sync` high 2 cycles. `busy` high 32 cycles.
3. No ready after the request -> after 16 cycles `underrun_count`=1 and 0x28A0 is re-sent. With `REQUESTER_UNDERRUN_MUTE_EN`: `held_sample`=0 and zeros are sent.
4. Ready asserted with the request pulse (ignored), then ready on the timeout edge with 1300 -> `held_sample`=1300, `underrun_count` unchanged.
5. `enable` dropped in WAIT -> IDLE, no underrun, no further pulses. Reset pulsed mid-word -> `sdata`, `busy` and `frame_sync` go to 0 immediately.
6. 260 consecutive timeouts -> `underrun_count` saturates at 255.
